act_sequencer: RTL

Command-driven controller that sequences the activation-function datapath over a vector held in data memory. It accepts one command (opcode, source address, destination address, element count), then for each element: reads memory, issues the operand to the activation unit, waits for its result, and writes the result back. It sits between the custom-instruction decode stage (command side) and the shared data-memory port and activation unit (datapath side), and reports done/error status back to decode.

---
 rtl/act_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/act_sequencer.sv
// act_sequencer: command-driven sequencer streaming a vector through the activation unit
module act_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [6:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
  input  logic [DIM_WIDTH-1:0]  cmd_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  act_valid,
  output logic [6:0]            act_opcode,
  output logic [DATA_WIDTH-1:0] act_data,
  input  logic                  act_res_valid,
  input  logic [DATA_WIDTH-1:0] act_res_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DIM_WIDTH-1:0]  elem_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT_RD, ISSUE, WAIT_RES, WRITE, DONE, ERR} state_t;

  state_t                state_q, state_d;
  logic [6:0]            opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [DIM_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d, cnt_inc;
  logic [DATA_WIDTH-1:0] operand_q, operand_d, result_q, result_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  ready_q, ready_d, rd_en_q, rd_en_d, act_valid_q, act_valid_d;
  logic                  wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic                  legal;

  assign legal   = (cmd_opcode == 7'h4A) || (cmd_opcode == 7'h4B);
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state and next-output decode; outputs are registered off the next state so they line up with it
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    result_d  = result_q;
    tmo_d     = tmo_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        opcode_d = cmd_opcode;
        src_d    = cmd_src_addr;
        dst_d    = cmd_dst_addr;
        len_d    = cmd_len;
        cnt_d    = '0;
        state_d  = !legal ? ERR : (cmd_len == '0) ? DONE : READ;
      end
      READ:    state_d = WAIT_RD;
      WAIT_RD: begin
        operand_d = mem_rd_data;
        state_d   = ISSUE;
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT_RES;
      end
      WAIT_RES: if (act_res_valid) begin
        result_d = act_res_data;
        state_d  = WRITE;
      end else if (tmo_q == TW'(TIMEOUT)) begin
        state_d = ERR;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      WRITE: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == len_q) ? DONE : READ;
      end
      default: state_d = IDLE;
    endcase
    ready_d     = state_d == IDLE;
    busy_d      = state_d != IDLE;
    rd_en_d     = state_d == READ;
    act_valid_d = state_d == ISSUE;
    wr_en_d     = state_d == WRITE;
    done_d      = state_d == DONE;
    err_d       = state_d == ERR;
    rd_addr_d   = src_d + ADDR_WIDTH'(cnt_d);
    wr_addr_d   = dst_d + ADDR_WIDTH'(cnt_d);
  end

  // State, command latches and registered outputs; async reset abandons any command in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      operand_q   <= '0;
      result_q    <= '0;
      tmo_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      act_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      operand_q   <= operand_d;
      result_q    <= result_d;
      tmo_q       <= tmo_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      act_valid_q <= act_valid_d;
      wr_en_q     <= wr_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign cmd_ready   = ready_q;
  assign busy        = busy_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign act_valid   = act_valid_q;
  assign act_opcode  = opcode_q;
  assign act_data    = operand_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = wr_addr_q;
  assign mem_wr_data = result_q;
  assign done        = done_q;
  assign err         = err_q;
  assign elem_cnt    = cnt_q;
endmodule
